// File: rtl/fb_clear_sequencer.sv
// Purpose : sequences framebuffer clears across NUM_UNITS clear units (bit 0 = colour), one unit at a time.
// Latency : accept at cycle 0, DRAIN at 1, first apply at 2 (pipe_idle high); 3 cycles minimum between unit applies.
// Backpr. : s_cmd_tready is high only in IDLE; a command held valid while busy waits and is never dropped.
//
// Ports   : aclk/resetn (async active-low); s_cmd_* command handshake + unit mask; pipe_idle in / pipe_hold out
//           fragment drain control; unit_apply (1-cycle pulse) / unit_applied (unit idle) per clear unit;
//           busy, done (1-cycle pulse), last_clear_cycles (duration of the last command).
// Option  : define FB_CLEAR_CYCLE_COUNT_EN to build the cycle counter behind last_clear_cycles
//           (otherwise the port is tied to 0; the port list is the same either way).
module fb_clear_sequencer #(
  parameter int NUM_UNITS = 3,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 aclk,
  input  logic                 resetn,
  input  logic                 s_cmd_tvalid,
  output logic                 s_cmd_tready,
  input  logic [NUM_UNITS-1:0] s_cmd_tmask,
  input  logic                 pipe_idle,
  output logic                 pipe_hold,
  output logic [NUM_UNITS-1:0] unit_apply,
  input  logic [NUM_UNITS-1:0] unit_applied,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] last_clear_cycles
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DRAIN = 3'd1,
    S_APPLY = 3'd2,
    S_ARM   = 3'd3,
    S_WAIT  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t                 state_q, state_d;
  logic [NUM_UNITS-1:0]   remaining_q, remaining_d;
  logic [NUM_UNITS-1:0]   unit_apply_q, unit_apply_d;
  logic                   active_q, active_d;
  logic                   done_q, done_d;
  logic [NUM_UNITS-1:0]   sel_oh;
  logic                   accept;

  // One-hot of the lowest set bit: units are served in ascending index order.
  function automatic logic [NUM_UNITS-1:0] lowest_onehot(input logic [NUM_UNITS-1:0] v);
    logic [NUM_UNITS-1:0] res;
    res = '0;
    for (int i = NUM_UNITS - 1; i >= 0; i--) begin
      if (v[i]) begin
        res    = '0;
        res[i] = 1'b1;
      end
    end
    return res;
  endfunction

  assign s_cmd_tready = (state_q == S_IDLE);
  assign accept       = s_cmd_tvalid & s_cmd_tready;

  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    // remaining is only modified in WAIT, so this still names the unit pulsed in APPLY.
    sel_oh       = lowest_onehot(remaining_q);
    case (state_q)
      S_IDLE: begin
        if (s_cmd_tvalid) begin
          remaining_d = s_cmd_tmask;
          state_d     = (s_cmd_tmask != '0) ? S_DRAIN : S_DONE;
        end
      end
      S_DRAIN: if (pipe_idle) state_d = S_APPLY;
      S_APPLY: state_d = S_ARM;
      // ARM gives the unit one cycle to drop its registered applied flag.
      S_ARM:   state_d = S_WAIT;
      S_WAIT: begin
        if ((unit_applied & sel_oh) != '0) begin
          remaining_d = remaining_q & ~sel_oh;
          state_d     = (remaining_d != '0) ? S_APPLY : S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered decodes of the next state so they line up with the state register.
    unit_apply_d = (state_d == S_APPLY) ? lowest_onehot(remaining_d) : '0;
    active_d     = (state_d != S_IDLE);
    done_d       = (state_d == S_DONE);
  end

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      remaining_q  <= '0;
      unit_apply_q <= '0;
      active_q     <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      unit_apply_q <= unit_apply_d;
      active_q     <= active_d;
      done_q       <= done_d;
    end
  end

  assign unit_apply = unit_apply_q;
  assign pipe_hold  = active_q;
  assign busy       = active_q;
  assign done       = done_q;

`ifdef FB_CLEAR_CYCLE_COUNT_EN
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] last_q, last_d;

  always_comb begin
    cnt_d  = cnt_q;
    last_d = last_q;
    if (accept) begin
      cnt_d = '0;
    end else if (active_q && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
    // Capture including the DONE cycle itself, so the result is the number of busy cycles.
    if (state_q == S_DONE) last_d = cnt_d;
  end

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      cnt_q  <= '0;
      last_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      last_q <= last_d;
    end
  end

  assign last_clear_cycles = last_q;
`else
  assign last_clear_cycles = '0;
`endif

endmodule

// File: tb/tb_fb_clear_sequencer.sv
// Bench for fb_clear_sequencer: directed scenarios followed by random commands, all applies and done pulses
// checked by a monitor against an expected-event queue filled when each command is accepted.
module tb_fb_clear_sequencer;
  localparam int NU = 3;
  localparam int CW = 32;

  logic          aclk = 1'b0;
  logic          resetn = 1'b0;
  logic          s_cmd_tvalid = 1'b0;
  logic          s_cmd_tready;
  logic [NU-1:0] s_cmd_tmask = '0;
  logic          pipe_idle = 1'b1;
  logic          pipe_hold;
  logic [NU-1:0] unit_apply;
  logic [NU-1:0] unit_applied = '1;
  logic          busy;
  logic          done;
  logic [CW-1:0] last_clear_cycles;

  fb_clear_sequencer #(.NUM_UNITS(NU), .CNT_WIDTH(CW)) dut (
    .aclk(aclk), .resetn(resetn),
    .s_cmd_tvalid(s_cmd_tvalid), .s_cmd_tready(s_cmd_tready), .s_cmd_tmask(s_cmd_tmask),
    .pipe_idle(pipe_idle), .pipe_hold(pipe_hold),
    .unit_apply(unit_apply), .unit_applied(unit_applied),
    .busy(busy), .done(done), .last_clear_cycles(last_clear_cycles)
  );

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc++;

  int n_total = 0;
  int n_pass  = 0;

  task automatic tally(input bit ok, input string name, input string detail);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: %s (cycle %0d)", name, detail, cyc);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tally(act === exp, name, $sformatf("got %0h, expected %0h", act, exp));
  endtask

  // Expected event stream: unit index for an apply, -1 for a done pulse.
  int exp_q[$];
  int acc_q[$];
  bit last_pend = 0;
  int last_exp  = 0;

  // Clear unit model: applied drops when apply is seen and returns high lat cycles later.
  int ucnt[NU];
  int ulat = 4;
  bit rand_lat = 0;
  always @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NU; i++) ucnt[i] = 0;
      unit_applied = '1;
    end else begin
      #1;
      for (int i = 0; i < NU; i++) begin
        if (ucnt[i] > 0) begin
          ucnt[i]--;
          if (ucnt[i] == 0) unit_applied[i] = 1'b1;
        end
        if (unit_apply[i]) begin
          ucnt[i] = rand_lat ? int'($urandom_range(1, 6)) : ulat;
          unit_applied[i] = 1'b0;
        end
      end
    end
  end

  // Monitor / scoreboard.
  always @(negedge aclk) begin
    if (resetn) begin
      chk("tready_vs_busy", s_cmd_tready, !busy);
      chk("hold_vs_busy", pipe_hold, busy);
      if (last_pend) begin
        chk("last_clear_cycles", last_clear_cycles, last_exp);
        last_pend = 0;
      end
      if (unit_apply != '0) begin
        if (exp_q.size() == 0 || exp_q[0] < 0) begin
          tally(0, "apply_unexpected", $sformatf("got apply %b, expected none", unit_apply));
        end else begin
          int e;
          e = exp_q.pop_front();
          chk("apply_order", unit_apply, 64'(1) << e);
        end
      end
      if (done) begin
        if (exp_q.size() == 0 || exp_q[0] != -1) begin
          tally(0, "done_unexpected", $sformatf("got done, expected %0d",
                                                 exp_q.size() ? exp_q[0] : -99));
        end else begin
          int a;
          void'(exp_q.pop_front());
          tally(1, "done_seq", "");
          a = (acc_q.size() > 0) ? acc_q.pop_front() : cyc;
`ifdef FB_CLEAR_CYCLE_COUNT_EN
          last_exp = cyc - a;
`else
          last_exp = 0;
`endif
          last_pend = 1;
        end
      end
    end
  end

  // Present a command and hold it until accepted; expectations are queued at the accept.
  task automatic issue(input logic [NU-1:0] m);
    int w = 0;
    bit acc = 0;
    int a = 0;
    s_cmd_tvalid = 1'b1;
    s_cmd_tmask  = m;
    while (!acc && w < 300) begin
      @(negedge aclk);
      acc = s_cmd_tready;
      a   = cyc;
      @(posedge aclk);
      #1;
      w++;
    end
    s_cmd_tvalid = 1'b0;
    s_cmd_tmask  = NU'($urandom);
    if (!acc) begin
      tally(0, "accept_timeout", $sformatf("mask %b not accepted in %0d cycles", m, w));
    end else begin
      for (int i = 0; i < NU; i++) if (m[i]) exp_q.push_back(i);
      exp_q.push_back(-1);
      acc_q.push_back(a);
    end
  endtask

  task automatic wait_done(input string tag);
    int w = 0;
    @(negedge aclk);
    while (!done && w < 200) begin
      @(negedge aclk);
      w++;
    end
    if (!done) begin
      tally(0, {tag, "_done_timeout"}, "done never pulsed");
    end else begin
      chk({tag, "_busy_in_done"}, busy, 1);
      chk({tag, "_hold_in_done"}, pipe_hold, 1);
      @(negedge aclk);
      chk({tag, "_busy_after"}, busy, 0);
      chk({tag, "_hold_after"}, pipe_hold, 0);
      chk({tag, "_tready_after"}, s_cmd_tready, 1);
    end
  endtask

  task automatic wait_idle(input string tag);
    int w = 0;
    @(negedge aclk);
    while ((busy || exp_q.size() != 0) && w < 1000) begin
      @(negedge aclk);
      w++;
    end
    chk({tag, "_drained"}, exp_q.size(), 0);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    exp_q.delete();
    acc_q.delete();
    last_pend = 0;
  endtask

  bit rnd_idle = 0;
  initial begin
    forever begin
      @(posedge aclk);
      #1;
      if (rnd_idle) pipe_idle = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_total);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    repeat (2) @(negedge aclk);
    chk("rst_tready", s_cmd_tready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_hold", pipe_hold, 0);
    chk("rst_apply", unit_apply, 0);
    chk("rst_done", done, 0);
    chk("rst_last", last_clear_cycles, 0);
    @(posedge aclk); #1;
    resetn = 1'b1;
    repeat (2) @(posedge aclk); #1;

    // Mask 101: unit 0 at cycle 2, then unit 2, unit 1 skipped.
    ulat = 4;
    issue(3'b101);
    @(negedge aclk);
    chk("t1_drain_apply", unit_apply, 0);
    chk("t1_drain_busy", busy, 1);
    @(negedge aclk);
    chk("t1_first_apply", unit_apply, 3'b001);
    wait_done("t1");

    // Mask 000: done at cycle 1, no apply.
    @(negedge aclk);
    chk("t2_hold_before", pipe_hold, 0);
    @(posedge aclk); #1;
    issue(3'b000);
    @(negedge aclk);
    chk("t2_done", done, 1);
    chk("t2_hold", pipe_hold, 1);
    chk("t2_apply", unit_apply, 0);
    @(negedge aclk);
    chk("t2_done_after", done, 0);
    chk("t2_hold_after", pipe_hold, 0);

    // Mask 010 with the pipeline busy for 10 cycles.
    @(posedge aclk); #1;
    pipe_idle = 1'b0;
    issue(3'b010);
    for (int i = 0; i < 10; i++) begin
      @(negedge aclk);
      chk("t3_no_apply", unit_apply, 0);
      chk("t3_hold", pipe_hold, 1);
    end
    @(posedge aclk); #1;
    pipe_idle = 1'b1;
    @(negedge aclk);
    chk("t3_apply_early", unit_apply, 0);
    @(negedge aclk);
    chk("t3_apply", unit_apply, 3'b010);
    wait_done("t3");

    // Second command waits for the first one to complete.
    @(posedge aclk); #1;
    issue(3'b011);
    issue(3'b110);
    chk("t4_first_drained", exp_q.size(), 3);
    wait_idle("t4");

    // Reset in WAIT for unit 0.
    @(posedge aclk); #1;
    ulat = 8;
    issue(3'b001);
    repeat (3) @(negedge aclk);
    @(posedge aclk); #2;
    do_reset();
    #1;
    chk("t5_apply", unit_apply, 0);
    chk("t5_busy", busy, 0);
    chk("t5_tready", s_cmd_tready, 1);
    chk("t5_hold", pipe_hold, 0);
    @(posedge aclk); #1;
    resetn = 1'b1;
    @(posedge aclk); #1;

    // Reset while apply is high: the pulse drops without waiting for a clock.
    issue(3'b100);
    @(negedge aclk);
    @(posedge aclk); #2;
    chk("t5b_apply_hi", unit_apply, 3'b100);
    do_reset();
    #1;
    chk("t5b_apply_drop", unit_apply, 0);
    @(posedge aclk); #1;
    resetn = 1'b1;
    @(posedge aclk); #1;

    ulat = 4;
    issue(3'b001);
    wait_done("t5c");

    // Random commands, random unit latency and pipeline drain.
    rand_lat = 1;
    rnd_idle = 1;
    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 3)) @(posedge aclk);
      #1;
      issue(NU'($urandom));
    end
    rnd_idle = 0;
    @(posedge aclk); #2;
    pipe_idle = 1'b1;
    wait_idle("rnd");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
